// File: rtl/seq_pkg.sv
// Shared types for program_sequencer.
//   seq_cmd_t   : 3-bit decoded command from the control unit.
//   seq_state_t : sequencer FSM state.
package seq_pkg;
  localparam int SEQ_CMD_W = 3;

  typedef enum logic [SEQ_CMD_W-1:0] {
    SEQ_INC    = 3'd0,
    SEQ_JUMP   = 3'd1,
    SEQ_BRANCH = 3'd2,
    SEQ_CALL   = 3'd3,
    SEQ_RET    = 3'd4,
    SEQ_HALT   = 3'd5,
    SEQ_CLEAR  = 3'd6,
    SEQ_NOP    = 3'd7
  } seq_cmd_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } seq_state_t;
endpackage

// File: rtl/program_sequencer_if.sv
// Command/status bundle between the control unit and program_sequencer.
//   master : control unit side (drives cmd/cond/target, observes status)
//   slave  : sequencer side
//   cmd, cond, target          : command inputs to the sequencer
//   pc, depth, halted, fault,
//   stack_overflow/underflow   : sequencer status
interface program_sequencer_if #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
);
  import seq_pkg::*;
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  seq_cmd_t            cmd;
  logic                cond;
  logic [PC_W-1:0]     target;
  logic [PC_W-1:0]     pc;
  logic [DEPTH_W-1:0]  depth;
  logic                halted;
  logic                fault;
  logic                stack_overflow;
  logic                stack_underflow;

  modport master (
    output cmd, cond, target,
    input  pc, depth, halted, fault, stack_overflow, stack_underflow
  );

  modport slave (
    input  cmd, cond, target,
    output pc, depth, halted, fault, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/return_stack.sv
// Bounded LIFO of return addresses.
//   clock, reset : rising-edge clock, async active-high reset (occupancy only)
//   push, wdata  : store wdata on top (ignored when full)
//   pop          : discard top entry (ignored when empty)
//   clear        : empty the stack; takes priority over push/pop
//   rdata        : current top entry (don't-care when empty)
//   depth, full, empty : occupancy
// Entry storage is not reset; only the occupancy counter is.
module return_stack #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [W-1:0]       wdata,
  output logic [W-1:0]       rdata,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [DEPTH_W-1:0]      cnt;
  logic [PTR_W-1:0]        wr_idx;
  logic [PTR_W-1:0]        rd_idx;

  // cnt never exceeds DEPTH, so its low bits address the next free slot;
  // one below (modulo the pointer width) is the top entry, also when full.
  assign wr_idx = cnt[PTR_W-1:0];
  assign rd_idx = wr_idx - PTR_W'(1);

  assign full  = (cnt == DEPTH_W'(DEPTH));
  assign empty = (cnt == '0);
  assign depth = cnt;
  assign rdata = mem[rd_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                cnt <= '0;
    else if (clear)           cnt <= '0;
    else if (push && !full)   cnt <= cnt + DEPTH_W'(1);
    else if (pop && !empty)   cnt <= cnt - DEPTH_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!clear && push && !full) mem[wr_idx] <= wdata;
  end
endmodule

// File: rtl/program_sequencer.sv
// Program counter and fetch sequencer.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (slave)  : cmd/cond/target in; pc, depth, halted, fault,
//                  stack_overflow, stack_underflow out
// Every command takes effect on the next rising edge; pc arithmetic wraps
// modulo 2^PC_W. HALTED and FAULT freeze everything until CLEAR.
// Build option PROGRAM_SEQUENCER_STACK_EN: when defined, a return_stack
// backs CALL/RET with overflow/underflow faults; when undefined, CALL acts
// as JUMP, RET as INC, and depth/fault flags are tied low.
module program_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  program_sequencer_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  seq_state_t       state, state_nxt;
  logic [PC_W-1:0]  pc_q, pc_nxt, pc_inc;

`ifdef PROGRAM_SEQUENCER_STACK_EN
  logic               push, pop, clr;
  logic [PC_W-1:0]    stk_top;
  logic [DEPTH_W-1:0] stk_depth;
  logic               stk_full, stk_empty;
  logic               ovf_q, ovf_nxt, unf_q, unf_nxt;

  return_stack #(
    .W       (PC_W),
    .DEPTH   (STACK_DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (clr),
    .wdata (pc_inc),
    .rdata (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );
`endif

  assign pc_inc = pc_q + PC_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

`ifdef PROGRAM_SEQUENCER_STACK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
`ifdef PROGRAM_SEQUENCER_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
    clr       = 1'b0;
    ovf_nxt   = ovf_q;
    unf_nxt   = unf_q;
`endif
    // CLEAR is honoured in every state; all other commands only in RUN.
    if (bus.cmd == SEQ_CLEAR) begin
      state_nxt = ST_RUN;
      pc_nxt    = '0;
`ifdef PROGRAM_SEQUENCER_STACK_EN
      clr       = 1'b1;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
`endif
    end else if (state == ST_RUN) begin
      case (bus.cmd)
        SEQ_INC:    pc_nxt = pc_inc;
        SEQ_JUMP:   pc_nxt = bus.target;
        SEQ_BRANCH: pc_nxt = bus.cond ? (pc_q + bus.target) : pc_inc;
`ifdef PROGRAM_SEQUENCER_STACK_EN
        SEQ_CALL: begin
          if (stk_full) begin
            ovf_nxt   = 1'b1;
            state_nxt = ST_FAULT;
          end else begin
            push   = 1'b1;
            pc_nxt = bus.target;
          end
        end
        SEQ_RET: begin
          if (stk_empty) begin
            unf_nxt   = 1'b1;
            state_nxt = ST_FAULT;
          end else begin
            pop    = 1'b1;
            pc_nxt = stk_top;
          end
        end
`else
        SEQ_CALL:   pc_nxt = bus.target;
        SEQ_RET:    pc_nxt = pc_inc;
`endif
        SEQ_HALT:   state_nxt = ST_HALTED;
        default:    ;
      endcase
    end
  end

  assign bus.pc     = pc_q;
  assign bus.halted = (state == ST_HALTED);
  assign bus.fault  = (state == ST_FAULT);
`ifdef PROGRAM_SEQUENCER_STACK_EN
  assign bus.depth           = stk_depth;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
`else
  assign bus.depth           = '0;
  assign bus.stack_overflow  = 1'b0;
  assign bus.stack_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer (PC_W=8, STACK_DEPTH=4).
// The driver applies a command at the falling edge and queues the state
// expected after the next rising edge; the monitor pops and compares 1 time
// unit after each rising edge. Stack vectors follow the build option.
module tb_program_sequencer;
  import seq_pkg::*;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [2:0] depth;
    logic       halted;
    logic       fault;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  program_sequencer_if #(.PC_W(8), .STACK_DEPTH(4)) bus ();

  program_sequencer #(.PC_W(8), .STACK_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input exp_t e);
    n_cmp++;
    if ({bus.pc, bus.depth, bus.halted, bus.fault, bus.stack_overflow, bus.stack_underflow}
        !== {e.pc, e.depth, e.halted, e.fault, e.ovf, e.unf}) begin
      n_bad++;
      $display("FAIL %s: got pc=%h depth=%0d halted=%b fault=%b ovf=%b unf=%b, want pc=%h depth=%0d halted=%b fault=%b ovf=%b unf=%b",
               e.name, bus.pc, bus.depth, bus.halted, bus.fault, bus.stack_overflow,
               bus.stack_underflow, e.pc, e.depth, e.halted, e.fault, e.ovf, e.unf);
    end
  endtask

  // Monitor: one expected entry per rising edge while commands are queued.
  always begin
    @(posedge clock);
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check(mon_e);
    end
  end

  task automatic drive(input string nm, input seq_cmd_t c, input logic cd,
                       input logic [7:0] t, input logic [7:0] pc,
                       input logic [2:0] d, input logic h, input logic f,
                       input logic o, input logic u);
    exp_t e;
    @(negedge clock);
    bus.cmd    = c;
    bus.cond   = cd;
    bus.target = t;
    e = '{nm, pc, d, h, f, o, u};
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.cmd    = SEQ_NOP;
    bus.cond   = 1'b0;
    bus.target = 8'h00;
    reset      = 1'b1;
    repeat (2) @(negedge clock);
    e = '{"reset_state", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    check(e);
    reset = 1'b0;

    //     name          cmd         cond  tgt    pc     dep   h     f     ovf   unf
    drive("inc1",       SEQ_INC,    0, 8'h00, 8'h01, 3'd0, 0, 0, 0, 0);
    drive("inc2",       SEQ_INC,    0, 8'h00, 8'h02, 3'd0, 0, 0, 0, 0);
    drive("inc3",       SEQ_INC,    0, 8'h00, 8'h03, 3'd0, 0, 0, 0, 0);
    drive("jump_fe",    SEQ_JUMP,   0, 8'hFE, 8'hFE, 3'd0, 0, 0, 0, 0);
    drive("inc_ff",     SEQ_INC,    0, 8'h00, 8'hFF, 3'd0, 0, 0, 0, 0);
    drive("inc_wrap",   SEQ_INC,    0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
    drive("jump_10",    SEQ_JUMP,   0, 8'h10, 8'h10, 3'd0, 0, 0, 0, 0);
    drive("br_back",    SEQ_BRANCH, 1, 8'hFC, 8'h0C, 3'd0, 0, 0, 0, 0);
    drive("jump_10b",   SEQ_JUMP,   0, 8'h10, 8'h10, 3'd0, 0, 0, 0, 0);
    drive("br_not",     SEQ_BRANCH, 0, 8'hFC, 8'h11, 3'd0, 0, 0, 0, 0);
    drive("nop",        SEQ_NOP,    1, 8'h55, 8'h11, 3'd0, 0, 0, 0, 0);
    drive("br_fwd",     SEQ_BRANCH, 1, 8'h7F, 8'h90, 3'd0, 0, 0, 0, 0);

`ifdef PROGRAM_SEQUENCER_STACK_EN
    drive("jump_05",    SEQ_JUMP,   0, 8'h05, 8'h05, 3'd0, 0, 0, 0, 0);
    drive("call_40",    SEQ_CALL,   0, 8'h40, 8'h40, 3'd1, 0, 0, 0, 0);
    drive("call_80",    SEQ_CALL,   0, 8'h80, 8'h80, 3'd2, 0, 0, 0, 0);
    drive("ret_41",     SEQ_RET,    0, 8'h00, 8'h41, 3'd1, 0, 0, 0, 0);
    drive("ret_06",     SEQ_RET,    0, 8'h00, 8'h06, 3'd0, 0, 0, 0, 0);
    drive("call_d1",    SEQ_CALL,   0, 8'h10, 8'h10, 3'd1, 0, 0, 0, 0);
    drive("call_d2",    SEQ_CALL,   0, 8'h20, 8'h20, 3'd2, 0, 0, 0, 0);
    drive("call_d3",    SEQ_CALL,   0, 8'h30, 8'h30, 3'd3, 0, 0, 0, 0);
    drive("call_d4",    SEQ_CALL,   0, 8'h40, 8'h40, 3'd4, 0, 0, 0, 0);
    drive("call_ovf",   SEQ_CALL,   0, 8'h50, 8'h40, 3'd4, 0, 1, 1, 0);
    drive("fault_inc",  SEQ_INC,    0, 8'h00, 8'h40, 3'd4, 0, 1, 1, 0);
    drive("fault_ret",  SEQ_RET,    0, 8'h00, 8'h40, 3'd4, 0, 1, 1, 0);
    drive("clear_ovf",  SEQ_CLEAR,  0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
    drive("ret_unf",    SEQ_RET,    0, 8'h00, 8'h00, 3'd0, 0, 1, 0, 1);
    drive("fault_call", SEQ_CALL,   0, 8'h55, 8'h00, 3'd0, 0, 1, 0, 1);
    drive("clear_unf",  SEQ_CLEAR,  0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
    drive("call_60",    SEQ_CALL,   0, 8'h60, 8'h60, 3'd1, 0, 0, 0, 0);
    drive("ret_01",     SEQ_RET,    0, 8'h00, 8'h01, 3'd0, 0, 0, 0, 0);
`else
    drive("jump_2f",    SEQ_JUMP,   0, 8'h2F, 8'h2F, 3'd0, 0, 0, 0, 0);
    drive("call_jump",  SEQ_CALL,   0, 8'h30, 8'h30, 3'd0, 0, 0, 0, 0);
    drive("ret_inc",    SEQ_RET,    0, 8'h00, 8'h31, 3'd0, 0, 0, 0, 0);
    drive("ret_inc2",   SEQ_RET,    0, 8'h00, 8'h32, 3'd0, 0, 0, 0, 0);
    drive("call_a",     SEQ_CALL,   0, 8'h40, 8'h40, 3'd0, 0, 0, 0, 0);
    drive("call_b",     SEQ_CALL,   0, 8'h41, 8'h41, 3'd0, 0, 0, 0, 0);
    drive("call_c",     SEQ_CALL,   0, 8'h42, 8'h42, 3'd0, 0, 0, 0, 0);
    drive("call_d",     SEQ_CALL,   0, 8'h43, 8'h43, 3'd0, 0, 0, 0, 0);
    drive("call_e",     SEQ_CALL,   0, 8'h44, 8'h44, 3'd0, 0, 0, 0, 0);
    drive("clear_run",  SEQ_CLEAR,  0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
`endif

    drive("jump_22",    SEQ_JUMP,   0, 8'h22, 8'h22, 3'd0, 0, 0, 0, 0);
    drive("halt",       SEQ_HALT,   0, 8'h00, 8'h22, 3'd0, 1, 0, 0, 0);
    drive("halt_inc1",  SEQ_INC,    0, 8'h00, 8'h22, 3'd0, 1, 0, 0, 0);
    drive("halt_inc2",  SEQ_INC,    0, 8'h00, 8'h22, 3'd0, 1, 0, 0, 0);
    drive("halt_jump",  SEQ_JUMP,   0, 8'h77, 8'h22, 3'd0, 1, 0, 0, 0);
    drive("halt_clear", SEQ_CLEAR,  0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
    drive("jump_22b",   SEQ_JUMP,   0, 8'h22, 8'h22, 3'd0, 0, 0, 0, 0);
    drive("halt2",      SEQ_HALT,   0, 8'h00, 8'h22, 3'd0, 1, 0, 0, 0);
    drive("halt2_inc",  SEQ_INC,    0, 8'h00, 8'h22, 3'd0, 1, 0, 0, 0);

    // Asynchronous reset in the middle of the low phase, away from any edge.
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    e = '{"mid_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    check(e);
    bus.cmd = SEQ_NOP;
    @(negedge clock);
    reset = 1'b0;
    drive("post_rst",   SEQ_INC,    0, 8'h00, 8'h01, 3'd0, 0, 0, 0, 0);

    repeat (3) @(negedge clock);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left in scoreboard, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised program-counter and fetch sequencer for the processor family; it replaces the fixed 8-bit load/increment counter. Each cycle it takes a decoded command from the control unit: increment, absolute jump, conditional relative branch, call, return, hold, halt or clear. It drives the instruction address `pc` and keeps a bounded return-address stack. Stack overflow and underflow are reported as sticky faults.

## Interface
Parameters:
- `PC_W`, 8, width of `pc` and `target`.
- `STACK_DEPTH`, 4, return-stack entries (≥1).

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; forces every register to its reset value immediately.
- `cmd` in 3: `seq_cmd_t` command, sampled every cycle.
- `cond` in 1: branch condition, used only with `SEQ_BRANCH`.
- `target` in `PC_W`: absolute address (JUMP, CALL) or two's-complement offset (BRANCH).
- `pc` out `PC_W`: current instruction address (registered).
- `depth` out `$clog2(STACK_DEPTH+1)`: occupied stack entries.
- `halted` out 1: high in the HALTED state.
- `fault` out 1: high in the FAULT state.
- `stack_overflow` out 1: sticky; set by CALL when the stack is full.
- `stack_underflow` out 1: sticky; set by RET when the stack is empty.

## Operation
- FSM states: RUN, HALTED, FAULT. Reset state is RUN.
- RUN, per `cmd`:
  - INC: `pc+1`.
  - JUMP: `target`.
  - BRANCH: `pc+target` if `cond`, else `pc+1`.
  - CALL: push `pc+1`, load `target`.
  - RET: pop into `pc`.
  - NOP: `pc` unchanged.
  - HALT: `pc` unchanged, go to HALTED.
  - CLEAR: `pc=0`, `depth=0`, flags cleared.
- All `pc` arithmetic is modulo 2^`PC_W`, so `pc+1` wraps from all-ones to 0.
- CALL with `depth==STACK_DEPTH`:
  - no push; `pc` holds.
  - `stack_overflow` is set; go to FAULT.
- RET with `depth==0`:
  - no pop; `pc` holds.
  - `stack_underflow` is set; go to FAULT.
- HALTED and FAULT:
  - `pc`, `depth` and the stack are frozen.
  - every `cmd` except CLEAR is ignored.
  - CLEAR returns to RUN with `pc=0`, `depth=0` and both flags cleared.
- Stack contents beyond `depth` are don't-care and are not cleared.

## Timing
- Reset values: `pc=0`, `depth=0`, `halted=0`, `fault=0`, `stack_overflow=0`, `stack_underflow=0`.
- Latency: one cycle. The `cmd` sampled at edge N is reflected on `pc`, `depth` and the flags after edge N.
- `halted` and `fault` are decoded from the state register, so they also change after edge N.
- RET immediately after CALL returns the just-pushed address; there is no bubble.
- `reset` asserted mid-cycle clears all outputs asynchronously. Deassertion must be synchronous to `clock` (handled outside the block). The first command is taken on the first edge after release.

## Configuration
- `PROGRAM_SEQUENCER_STACK_EN`
- Defined:
  - return stack, `depth`, CALL/RET and both fault flags are implemented as above.
- Undefined:
  - no stack storage.
  - CALL behaves as JUMP; RET behaves as INC.
  - `depth`, `stack_overflow` and `stack_underflow` are tied to 0.
  - FAULT is unreachable.

## Structure
- Package `seq_pkg`:
  - `seq_cmd_t` enum: INC=0, JUMP=1, BRANCH=2, CALL=3, RET=4, HALT=5, CLEAR=6, NOP=7.
  - `SEQ_CMD_W=3`.
  - `seq_state_t` enum: RUN, HALTED, FAULT.
- Sub-module `return_stack`, a parametrised LIFO:
  - inputs: push, pop, `wdata`, clear.
  - outputs: `rdata` (top of stack), `depth`, `full`, `empty`.
  - instantiated only under `PROGRAM_SEQUENCER_STACK_EN`.
- Top level: FSM, `pc` register and next-`pc` mux.

## Test plan
Defaults (`PC_W=8`, `STACK_DEPTH=4`), macro defined unless noted.
- Reset, then INC ×3 → `pc` 1, 2, 3. JUMP 8'hFE, then INC ×2 → `pc` FF, 00.
- `pc`=8'h10, BRANCH `target`=8'hFC, `cond`=1 → `pc`=8'h0C. With `cond`=0 → `pc`=8'h11.
- Nested calls and returns:
  - `pc`=8'h05, CALL 8'h40 → `pc`=8'h40, `depth`=1.
  - CALL 8'h80 → `depth`=2.
  - RET → `pc`=8'h41, `depth`=1.
  - RET → `pc`=8'h06, `depth`=0.
- Overflow and recovery:
  - Five consecutive CALLs → 5th gives `stack_overflow`=1, `fault`=1, `pc` unchanged, `depth`=4.
  - INC is then ignored.
  - CLEAR → `pc`=0, `depth`=0, flags 0, RUN.
- RET at `depth`=0 → `stack_underflow`=1, `fault`=1, `pc` unchanged.
- Halt and reset:
  - HALT at `pc`=8'h22 → `halted`=1; `pc` stays 8'h22 over 3 INCs.
  - `reset` pulse mid-cycle → `pc`=0 and `halted`=0 before the next edge.
  - Macro undefined: CALL 8'h30 → `pc`=8'h30, `depth`=0; RET → `pc`=8'h31.
